// File: rtl/ervp_multi_latency_monitor_pkg.sv
// Shared definitions for the multi-channel latency monitor: detection-mode
// encodings used by the top and the per-channel logic.
package ervp_multi_latency_monitor_pkg;

  typedef enum logic {
    DETECT_ABS = 1'b0,  // absolute threshold only
    DETECT_AVG = 1'b1   // threshold and half-latency above running average
  } detect_mode_e;

  localparam int DEFAULT_NUM_CH        = 4;
  localparam int DEFAULT_BW_COUNTER    = 16;
  localparam int DEFAULT_TIMEOUT_LIMIT = 500;
  localparam int DEFAULT_BW_EVENT      = 16;
  localparam int DEFAULT_AVG_SHIFT     = 3;

endpackage

// File: rtl/ervp_multi_latency_monitor_channel.sv
// One monitored channel: saturating latency counter, max/running-average
// statistics, sticky timeout flag with rise pulse, and timeout event counter.
module ervp_multi_latency_monitor_channel
  import ervp_multi_latency_monitor_pkg::*;
#(
  parameter int BW_COUNTER    = DEFAULT_BW_COUNTER,
  parameter int TIMEOUT_LIMIT = DEFAULT_TIMEOUT_LIMIT,
  parameter int BW_EVENT      = DEFAULT_BW_EVENT,
  parameter int DETECT_MODE   = int'(DETECT_ABS),
  parameter int AVG_SHIFT     = DEFAULT_AVG_SHIFT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  ch_init,
  input  logic                  ch_count,
  input  logic                  clear_stats,
  output logic                  timeout,
  output logic                  timeout_rise,
  output logic [BW_COUNTER-1:0] cur_latency,
  output logic [BW_COUNTER-1:0] max_latency,
  output logic [BW_COUNTER-1:0] avg_latency,
  output logic [BW_EVENT-1:0]   event_count
);

  localparam logic [BW_COUNTER-1:0] LIMIT = BW_COUNTER'(TIMEOUT_LIMIT);

  logic                         armed;
  logic                         avg_valid;
  logic signed [BW_COUNTER:0]   avg_diff;
  logic signed [BW_COUNTER:0]   avg_step;
  logic        [BW_COUNTER-1:0] avg_next;
  logic                         above_avg;
  logic                         set_timeout;
  logic                         stat_update;

  // One extra sign bit keeps (cur - avg) exact before the weighted shift.
  always_comb begin
    avg_diff    = $signed({1'b0, cur_latency}) - $signed({1'b0, avg_latency});
    avg_step    = avg_diff >>> AVG_SHIFT;
    avg_next    = BW_COUNTER'($signed({1'b0, avg_latency}) + avg_step);
    above_avg   = (cur_latency >> 1) > avg_latency;
    set_timeout = !timeout && (cur_latency >= LIMIT) &&
                  ((DETECT_MODE != int'(DETECT_AVG)) || !avg_valid || above_avg);
    stat_update = ch_init && armed;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_latency  <= '0;
      max_latency  <= '0;
      avg_latency  <= '0;
      avg_valid    <= 1'b0;
      armed        <= 1'b0;
      timeout      <= 1'b0;
      timeout_rise <= 1'b0;
      event_count  <= '0;
    end else if (enable) begin
      if (ch_init) begin
        cur_latency <= '0;
      end else if (ch_count && !(&cur_latency)) begin
        cur_latency <= cur_latency + 1'b1;
      end

      if (ch_init) begin
        armed <= 1'b1;
      end

      if (ch_init) begin
        timeout <= 1'b0;
      end else if (set_timeout) begin
        timeout <= 1'b1;
      end
      timeout_rise <= set_timeout && !ch_init;

      // Clearing wins over a statistic update landing in the same cycle.
      if (clear_stats) begin
        max_latency <= '0;
        avg_latency <= '0;
        avg_valid   <= 1'b0;
        event_count <= '0;
      end else if (stat_update) begin
        if (cur_latency > max_latency) begin
          max_latency <= cur_latency;
        end
        if (!avg_valid) begin
          avg_latency <= cur_latency;
          avg_valid   <= 1'b1;
        end else begin
          avg_latency <= avg_next;
        end
        if (timeout && !(&event_count)) begin
          event_count <= event_count + 1'b1;
        end
      end
    end else begin
      timeout_rise <= 1'b0;
    end
  end

endmodule

// File: rtl/ervp_multi_latency_monitor.sv
// Multi-channel latency monitor top: replicates the channel logic, packs the
// per-channel results and reduces the timeout flags.
module ervp_multi_latency_monitor
  import ervp_multi_latency_monitor_pkg::*;
#(
  parameter int NUM_CH        = DEFAULT_NUM_CH,
  parameter int BW_COUNTER    = DEFAULT_BW_COUNTER,
  parameter int TIMEOUT_LIMIT = DEFAULT_TIMEOUT_LIMIT,
  parameter int BW_EVENT      = DEFAULT_BW_EVENT,
  parameter int DETECT_MODE   = int'(DETECT_ABS),
  parameter int AVG_SHIFT     = DEFAULT_AVG_SHIFT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [NUM_CH-1:0]            ch_init,
  input  logic [NUM_CH-1:0]            ch_count,
  input  logic                         clear_stats,
  output logic [NUM_CH-1:0]            timeout,
  output logic [NUM_CH-1:0]            timeout_rise,
  output logic                         any_timeout,
  output logic [NUM_CH*BW_COUNTER-1:0] cur_latency,
  output logic [NUM_CH*BW_COUNTER-1:0] max_latency,
  output logic [NUM_CH*BW_COUNTER-1:0] avg_latency,
  output logic [NUM_CH*BW_EVENT-1:0]   event_count
);

  // A limit the counter can never reach would silently disable detection.
  if (64'(TIMEOUT_LIMIT) >= (64'd1 << BW_COUNTER)) begin : g_limit_check
    $error("TIMEOUT_LIMIT must be below 2**BW_COUNTER");
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    ervp_multi_latency_monitor_channel #(
      .BW_COUNTER   (BW_COUNTER),
      .TIMEOUT_LIMIT(TIMEOUT_LIMIT),
      .BW_EVENT     (BW_EVENT),
      .DETECT_MODE  (DETECT_MODE),
      .AVG_SHIFT    (AVG_SHIFT)
    ) u_channel (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .ch_init     (ch_init[gi]),
      .ch_count    (ch_count[gi]),
      .clear_stats (clear_stats),
      .timeout     (timeout[gi]),
      .timeout_rise(timeout_rise[gi]),
      .cur_latency (cur_latency[gi*BW_COUNTER +: BW_COUNTER]),
      .max_latency (max_latency[gi*BW_COUNTER +: BW_COUNTER]),
      .avg_latency (avg_latency[gi*BW_COUNTER +: BW_COUNTER]),
      .event_count (event_count[gi*BW_EVENT +: BW_EVENT])
    );
  end

  assign any_timeout = |timeout;

endmodule
